simd_scheduler: RTL and testbench

Per-SIMD control state machine that drives the program counter and sequences one wave through fetch, decode, memory request/wait, execute and update. It produces the `simd_state` and `dispatch_new_wave` signals consumed by the SIMD unit's PC. It also runs the program-memory read handshake using the PC value. Each SIMD unit hosts at most one wave; there is no branching.

---
 rtl/simd_scheduler.sv | 112 +++++++++++
 tb/tb_simd_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/simd_scheduler.sv
// simd_scheduler
//   Per-SIMD control FSM. Sequences a single wave through
//   FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE and repeats until
//   the decoder flags RET, then parks in DONE until the dispatcher hands over
//   a new wave. It also runs the program-memory read handshake from the PC.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   enable                SIMD enable; low freezes state and instruction
//   wave_start            dispatcher offers a new wave (level)
//   dispatch_new_wave     comb pulse: wave accepted this cycle, PC resets
//   pc                    current PC from the PC block
//   prog_mem_read_*       instruction read request/response
//   instruction           latched instruction word, routed to the decoder
//   decoded_ret           decoder says current instruction is RET
//   lsu_busy              per-lane LSU outstanding-access flags
//   simd_state            current FSM state (consumed by the PC block)
//   wave_done             wave has retired RET
module simd_scheduler #(
    parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
    parameter int INSTR_WIDTH            = 16,
    parameter int LANES                  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              wave_start,
    output logic                              dispatch_new_wave,
    input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc,
    output logic                              prog_mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] prog_mem_read_addr,
    input  logic                              prog_mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]            prog_mem_read_data,
    output logic [INSTR_WIDTH-1:0]            instruction,
    input  logic                              decoded_ret,
    input  logic [LANES-1:0]                  lsu_busy,
    output logic [2:0]                        simd_state,
    output logic                              wave_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } state_t;

    state_t state, state_nxt;
    logic   fetch_hit;   // read response accepted this cycle
    logic   ret_hit;     // RET retired this cycle

    assign simd_state = state;

    always_comb begin
        state_nxt           = state;
        dispatch_new_wave   = 1'b0;
        prog_mem_read_valid = 1'b0;
        prog_mem_read_addr  = pc;
        fetch_hit           = 1'b0;
        ret_hit             = 1'b0;
        // Everything below is qualified by enable and !rst so that outputs
        // drop immediately when frozen or in reset.
        if (enable && !rst) begin
            case (state)
                IDLE, DONE: begin
                    if (wave_start) begin
                        dispatch_new_wave = 1'b1;
                        state_nxt         = FETCH;
                    end
                end
                FETCH: begin
                    prog_mem_read_valid = 1'b1;
                    if (prog_mem_read_ready) begin
                        fetch_hit = 1'b1;
                        state_nxt = DECODE;
                    end
                end
                DECODE:  state_nxt = REQUEST;
                REQUEST: state_nxt = WAIT;
                WAIT:    if (lsu_busy == '0) state_nxt = EXECUTE;
                EXECUTE: state_nxt = UPDATE;
                UPDATE: begin
                    if (decoded_ret) begin
                        ret_hit   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= '0;
            wave_done   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fetch_hit)         instruction <= prog_mem_read_data;
            if (dispatch_new_wave) wave_done   <= 1'b0;
            else if (ret_hit)      wave_done   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_simd_scheduler.sv
// tb_simd_scheduler
//   Directed stimulus with a per-cycle scoreboard. The stimulus process pushes
//   the expected observable outputs for each cycle into a queue; a monitor on
//   the falling edge pops and compares against what the DUT presents.
//   A small PC block model (reset on dispatch, +1 leaving EXECUTE) drives pc.
module tb_simd_scheduler;

    localparam int AW = 32;
    localparam int IW = 16;
    localparam int LN = 4;

    localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DEC = 3'b010,
                           S_REQ  = 3'b011, S_WAIT  = 3'b100, S_EXE = 3'b101,
                           S_UPD  = 3'b110, S_DONE  = 3'b111;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          wave_start;
    logic          dispatch_new_wave;
    logic [AW-1:0] pc;
    logic          prog_mem_read_valid;
    logic [AW-1:0] prog_mem_read_addr;
    logic          prog_mem_read_ready;
    logic [IW-1:0] prog_mem_read_data;
    logic [IW-1:0] instruction;
    logic          decoded_ret;
    logic [LN-1:0] lsu_busy;
    logic [2:0]    simd_state;
    logic          wave_done;

    simd_scheduler #(.PROGRAM_MEM_ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wave_start(wave_start),
        .dispatch_new_wave(dispatch_new_wave), .pc(pc),
        .prog_mem_read_valid(prog_mem_read_valid), .prog_mem_read_addr(prog_mem_read_addr),
        .prog_mem_read_ready(prog_mem_read_ready), .prog_mem_read_data(prog_mem_read_data),
        .instruction(instruction), .decoded_ret(decoded_ret), .lsu_busy(lsu_busy),
        .simd_state(simd_state), .wave_done(wave_done)
    );

    always #5 clk = ~clk;

    // PC block model
    always @(posedge clk) begin
        if (rst)                                pc <= '0;
        else if (dispatch_new_wave)             pc <= '0;
        else if (enable && simd_state == S_EXE) pc <= pc + 1;
    end

    typedef struct {
        string         name;
        logic [2:0]    st;
        logic          vld;
        logic [AW-1:0] addr;
        logic          disp;
        logic          done;
        logic [IW-1:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: one expected snapshot per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (simd_state !== e.st || prog_mem_read_valid !== e.vld ||
                dispatch_new_wave !== e.disp || wave_done !== e.done ||
                instruction !== e.instr || (e.vld && prog_mem_read_addr !== e.addr)) begin
                failures++;
                $display("FAIL %s: got st=%b vld=%b addr=%0h disp=%b done=%b instr=%h, need st=%b vld=%b addr=%0h disp=%b done=%b instr=%h",
                         e.name, simd_state, prog_mem_read_valid, prog_mem_read_addr,
                         dispatch_new_wave, wave_done, instruction,
                         e.st, e.vld, e.addr, e.disp, e.done, e.instr);
            end
        end
    end

    // Push the expectation for the current cycle, then advance one clock.
    task automatic cyc(input string nm, input logic [2:0] st, input logic vld,
                       input logic [AW-1:0] addr, input logic disp, input logic done,
                       input logic [IW-1:0] instr);
        exp_t e;
        e.name = nm; e.st = st; e.vld = vld; e.addr = addr;
        e.disp = disp; e.done = done; e.instr = instr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; wave_start = 1'b0; prog_mem_read_ready = 1'b0;
        prog_mem_read_data = '0; decoded_ret = 1'b0; lsu_busy = '0;
        @(posedge clk); #1;
        // Reset held for a second cycle; wave_start must not leak out.
        wave_start = 1'b1;
        cyc("reset",     S_IDLE, 0, 0, 0, 0, 16'h0000);
        rst = 1'b0;

        // Single non-RET instruction, ready in first FETCH cycle
        cyc("accept",    S_IDLE, 0, 0, 1, 0, 16'h0000);
        wave_start = 1'b0;
        prog_mem_read_ready = 1'b1; prog_mem_read_data = 16'h1234;
        cyc("fetch0",    S_FETCH, 1, 0, 0, 0, 16'h0000);
        prog_mem_read_ready = 1'b0; prog_mem_read_data = 16'hAAAA;
        cyc("decode0",   S_DEC,  0, 0, 0, 0, 16'h1234);
        cyc("request0",  S_REQ,  0, 0, 0, 0, 16'h1234);
        cyc("wait0",     S_WAIT, 0, 0, 0, 0, 16'h1234);
        cyc("exec0",     S_EXE,  0, 0, 0, 0, 16'h1234);
        cyc("update0",   S_UPD,  0, 0, 0, 0, 16'h1234);

        // Fetch stall: 3 not-ready cycles, ready on the 4th; PC is now 1
        for (int i = 0; i < 3; i++)
            cyc("fetch_stall", S_FETCH, 1, 1, 0, 0, 16'h1234);
        prog_mem_read_ready = 1'b1; prog_mem_read_data = 16'h5678;
        cyc("fetch1_rdy", S_FETCH, 1, 1, 0, 0, 16'h1234);
        prog_mem_read_ready = 1'b0; prog_mem_read_data = 16'hAAAA;
        cyc("decode1",   S_DEC,  0, 0, 0, 0, 16'h5678);
        cyc("request1",  S_REQ,  0, 0, 0, 0, 16'h5678);

        // LSU wait: busy for 4 cycles, WAIT lasts 5 cycles
        lsu_busy = 4'b0101;
        for (int i = 0; i < 4; i++)
            cyc("wait_busy", S_WAIT, 0, 0, 0, 0, 16'h5678);
        lsu_busy = 4'b0000;
        cyc("wait_clear", S_WAIT, 0, 0, 0, 0, 16'h5678);
        cyc("exec1",     S_EXE,  0, 0, 0, 0, 16'h5678);
        decoded_ret = 1'b1;
        cyc("update_ret", S_UPD, 0, 0, 0, 0, 16'h5678);
        decoded_ret = 1'b0;

        // DONE: wave_done held; disabled wave_start is not accepted
        cyc("done_hold", S_DONE, 0, 0, 0, 1, 16'h5678);
        enable = 1'b0; wave_start = 1'b1;
        cyc("done_dis",  S_DONE, 0, 0, 0, 1, 16'h5678);
        enable = 1'b1;
        cyc("redispatch", S_DONE, 0, 0, 1, 1, 16'h5678);
        wave_start = 1'b0;

        // Enable freeze in FETCH: ready ignored, valid low, state held
        enable = 1'b0; prog_mem_read_ready = 1'b1; prog_mem_read_data = 16'h9999;
        for (int i = 0; i < 3; i++)
            cyc("freeze", S_FETCH, 0, 0, 0, 0, 16'h5678);
        enable = 1'b1; prog_mem_read_data = 16'h0ABC;
        cyc("fetch_new_wave", S_FETCH, 1, 0, 0, 0, 16'h5678);
        prog_mem_read_ready = 1'b0;
        cyc("decode2",   S_DEC,  0, 0, 0, 0, 16'h0ABC);
        cyc("request2",  S_REQ,  0, 0, 0, 0, 16'h0ABC);
        cyc("wait2",     S_WAIT, 0, 0, 0, 0, 16'h0ABC);
        wave_start = 1'b1;
        cyc("exec_ws",   S_EXE,  0, 0, 0, 0, 16'h0ABC);
        wave_start = 1'b0;
        cyc("update2",   S_UPD,  0, 0, 0, 0, 16'h0ABC);
        prog_mem_read_ready = 1'b1; prog_mem_read_data = 16'h0DEF;
        cyc("fetch3",    S_FETCH, 1, 1, 0, 0, 16'h0ABC);
        prog_mem_read_ready = 1'b0;
        cyc("decode3",   S_DEC,  0, 0, 0, 0, 16'h0DEF);
        cyc("request3",  S_REQ,  0, 0, 0, 0, 16'h0DEF);

        // Mid-wave reset in WAIT; a late memory response is ignored
        lsu_busy = 4'b1111;
        cyc("wait3",     S_WAIT, 0, 0, 0, 0, 16'h0DEF);
        rst = 1'b1;
        cyc("wait_rst",  S_WAIT, 0, 0, 0, 0, 16'h0DEF);
        rst = 1'b0; lsu_busy = '0;
        prog_mem_read_ready = 1'b1; prog_mem_read_data = 16'h7777;
        cyc("idle_after_rst", S_IDLE, 0, 0, 0, 0, 16'h0000);
        cyc("idle_late_rsp",  S_IDLE, 0, 0, 0, 0, 16'h0000);
        prog_mem_read_ready = 1'b0;

        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
